vga_pixel_feeder: RTL and testbench

//  Pixel-rate FIFO between the pixel source and vga_driver. Accepts RGB222 pixels

---
 rtl/vga_pixel_feeder.sv | 134 +++++++++++++
 tb/tb_vga_pixel_feeder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_feeder.sv
// Pixel-rate FIFO feeding vga_driver's wb_data byte. It frame-aligns on SOF marks,
// detects underflow and SOF/position misalignment, and re-locks on the next SOF.
module vga_pixel_feeder #(
    parameter int DEPTH   = 16,
    parameter int PREFILL = 8
) (
    input  logic                     clk_pix,
    input  logic                     rst_pix,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [5:0]               wr_data,
    input  logic                     wr_sof,
    input  logic [9:0]               sx,
    input  logic [9:0]               sy,
    input  logic                     de,
    output logic [7:0]               pix_out,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     running,
    output logic                     underflow,
    output logic                     misalign,
    input  logic                     clr_status
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
    localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);

    typedef enum logic [1:0] {FLUSH, SYNC, RUN} state_t;

    state_t            state_reg, state_next;
    logic [6:0]        mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]     level_reg;
    logic              underflow_reg, misalign_reg;
    logic              push, pop, empty, full;
    logic              head_sof, at_origin;
    logic [5:0]        head_rgb;
    logic              set_underflow, set_misalign;

    assign empty     = (level_reg == '0);
    assign full      = (level_reg == DEPTH_L);
    assign push      = wr_valid && !full;
    assign at_origin = (sx == 10'd0) && (sy == 10'd0);

    // Show-ahead head: the entry at the read pointer is always presented.
    assign {head_sof, head_rgb} = mem[rd_ptr_reg];

    always_ff @(posedge clk_pix) begin
        if (push) begin
            mem[wr_ptr_reg] <= {wr_sof, wr_data};
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            state_reg     <= SYNC;
            underflow_reg <= 1'b0;
            misalign_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            // A fresh event in the same cycle takes precedence over the clear.
            if (set_underflow)   underflow_reg <= 1'b1;
            else if (clr_status) underflow_reg <= 1'b0;
            if (set_misalign)    misalign_reg  <= 1'b1;
            else if (clr_status) misalign_reg  <= 1'b0;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pop           = 1'b0;
        pix_out       = 8'h03;
        set_underflow = 1'b0;
        set_misalign  = 1'b0;
        case (state_reg)
            FLUSH: begin
                if (!empty) begin
                    if (head_sof) state_next = SYNC;
                    else          pop = 1'b1;
                end
            end
            SYNC: begin
                if (!empty) begin
                    if (!head_sof)                           state_next = FLUSH;
                    else if (level_reg >= PREFILL_L || full) state_next = RUN;
                end
            end
            RUN: begin
                pix_out = 8'h00;
                if (de) begin
                    if (empty) begin
                        set_underflow = 1'b1;
                        state_next    = FLUSH;
                    end else if (head_sof && !at_origin) begin
                        // Early SOF: keep it at the head and hold the driver at 0,0.
                        set_misalign = 1'b1;
                        pix_out      = 8'h03;
                        state_next   = SYNC;
                    end else if (!head_sof && at_origin) begin
                        set_misalign = 1'b1;
                        pix_out      = 8'h03;
                        state_next   = FLUSH;
                    end else begin
                        pop     = 1'b1;
                        pix_out = {head_rgb, 2'b00};
                    end
                end
            end
            default: state_next = SYNC;
        endcase
    end

    assign wr_ready  = !full;
    assign level     = level_reg;
    assign running   = (state_reg == RUN);
    assign underflow = underflow_reg;
    assign misalign  = misalign_reg;
endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Bench for vga_pixel_feeder: a reduced-size driver model closes the 8'h03 hold loop,
// and a source queue feeds a scoreboard of expected pixel bytes.
module tb_vga_pixel_feeder;
    localparam int H_ACT = 8;
    localparam int H_TOT = 12;
    localparam int V_ACT = 4;
    localparam int V_TOT = 6;

    logic       clk_pix = 1'b0;
    logic       rst_pix = 1'b0;
    logic       wr_valid = 1'b0, wr_ready, wr_sof = 1'b0, de;
    logic [5:0] wr_data = '0;
    logic [9:0] sx, sy;
    logic [7:0] pix_out;
    logic [4:0] level;
    logic       running, underflow, misalign;
    logic       clr_status = 1'b0;

    logic       f_wr_valid = 1'b0, f_wr_ready, f_wr_sof = 1'b0, f_de = 1'b0;
    logic [5:0] f_wr_data = '0;
    logic [9:0] f_sx = '0, f_sy = '0;
    logic [7:0] f_pix_out;
    logic [4:0] f_level;
    logic       f_running, f_underflow, f_misalign;
    logic       f_clr = 1'b0;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [6:0] src_q[$];
    logic [6:0] exp_q[$];
    bit         pending = 1'b0;

    always #5 clk_pix = ~clk_pix;

    vga_pixel_feeder #(.DEPTH(16), .PREFILL(8)) dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_sof(wr_sof), .sx(sx), .sy(sy), .de(de), .pix_out(pix_out),
        .level(level), .running(running), .underflow(underflow), .misalign(misalign),
        .clr_status(clr_status)
    );

    vga_pixel_feeder #(.DEPTH(16), .PREFILL(16)) u_full (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .wr_valid(f_wr_valid), .wr_ready(f_wr_ready),
        .wr_data(f_wr_data), .wr_sof(f_wr_sof), .sx(f_sx), .sy(f_sy), .de(f_de),
        .pix_out(f_pix_out), .level(f_level), .running(f_running), .underflow(f_underflow),
        .misalign(f_misalign), .clr_status(f_clr)
    );

    // Driver model: 8'h03 in the low bits holds position at 0,0 on the next edge.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            sx <= '0;
            sy <= '0;
        end else if (pix_out[1:0] == 2'b11) begin
            sx <= '0;
            sy <= '0;
        end else if (sx == 10'(H_TOT - 1)) begin
            sx <= '0;
            sy <= (sy == 10'(V_TOT - 1)) ? 10'd0 : sy + 10'd1;
        end else begin
            sx <= sx + 10'd1;
        end
    end
    assign de = (sx < 10'(H_ACT)) && (sy < 10'(V_ACT));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] rgb_of(input int f, input int i);
        return 6'((i * 5 + f * 11 + 42) % 64);
    endfunction

    task automatic enq_frame(input int f, input int n);
        for (int i = 0; i < n; i++) src_q.push_back({i == 0, rgb_of(f, i)});
    endtask

    // Source driver + scoreboard in one process so retire-then-compare order is fixed.
    always @(negedge clk_pix) begin
        logic [6:0] e;
        if (rst_pix) begin
            pending = 1'b0;
            exp_q.delete();
            wr_valid = 1'b0;
        end else begin
            if (pending && src_q.size() > 0) exp_q.push_back(src_q.pop_front());
            pending = 1'b0;
            if (running && de && level != 5'd0 && pix_out[1:0] == 2'b00) begin
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL sb_pop: observed pop of %0h required no pop", pix_out);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_pix", 32'(pix_out), 32'({e[5:0], 2'b00}));
                    if (e[6]) check("sb_sof_pos", 32'({sy, sx}), 32'h0);
                end
            end
            if (running && !de) check("blank_zero", 32'(pix_out), 32'h0);
            wr_valid = (src_q.size() > 0);
            if (wr_valid) {wr_sof, wr_data} = src_q[0];
            pending = wr_valid && wr_ready;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        // Reset state
        #2 rst_pix = 1'b1;
        @(negedge clk_pix);
        check("rst_level", 32'(level), 32'h0);
        check("rst_pix_out", 32'(pix_out), 32'h03);
        check("rst_wr_ready", 32'(wr_ready), 32'h1);
        check("rst_flags", 32'({running, underflow, misalign}), 32'h0);
        @(negedge clk_pix);
        rst_pix = 1'b0;

        // Prefill then release at level 8; first popped byte is 8'hA8 at 0,0
        enq_frame(0, 32); enq_frame(1, 32); enq_frame(2, 32);
        cnt = 0;
        while (level < 5'd8 && cnt < 100) begin
            check("sync_hold", 32'(pix_out), 32'h03);
            @(negedge clk_pix); cnt++;
        end
        check("to_prefill", 32'(cnt < 100), 32'h1);
        check("prefill_not_run", 32'(running), 32'h0);
        check("prefill_pix", 32'(pix_out), 32'h03);
        @(negedge clk_pix);
        check("release_run", 32'(running), 32'h1);
        check("release_pos", 32'({sy, sx}), 32'h0);
        check("release_pix", 32'(pix_out), 32'hA8);

        // Three sustained frames drain without errors
        cnt = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0 || pending) && cnt < 2000) begin
            @(negedge clk_pix); cnt++;
        end
        check("to_frames", 32'(cnt < 2000), 32'h1);
        check("frames_flags", 32'({underflow, misalign}), 32'h0);

        // Stall mid-line: underflow, FLUSH holds 8'h03, then re-lock on SOF
        @(negedge clk_pix); rst_pix = 1'b1; src_q.delete();
        repeat (2) @(negedge clk_pix);
        rst_pix = 1'b0;
        enq_frame(3, 13);
        cnt = 0;
        while (!underflow && cnt < 300) begin @(negedge clk_pix); cnt++; end
        check("to_underflow", 32'(cnt < 300), 32'h1);
        check("uf_all_popped", 32'(exp_q.size()), 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("uf_hold", 32'({running, pix_out}), 32'h03);
            @(negedge clk_pix);
        end
        check("uf_sticky", 32'(underflow), 32'h1);
        clr_status = 1'b1;
        @(negedge clk_pix);
        clr_status = 1'b0;
        check("clr_underflow", 32'(underflow), 32'h0);
        enq_frame(4, 32); enq_frame(5, 29); enq_frame(6, 32);
        cnt = 0;
        while (!running && cnt < 200) begin @(negedge clk_pix); cnt++; end
        check("to_relock", 32'(cnt < 200), 32'h1);
        check("relock_pos", 32'({sy, sx}), 32'h0);

        // Early SOF at (5,3): misalign, SYNC at 0,0, restart from that SOF
        cnt = 0;
        while (!misalign && cnt < 500) begin @(negedge clk_pix); cnt++; end
        check("to_misalign", 32'(cnt < 500), 32'h1);
        check("ma_sync", 32'({running, pix_out}), 32'h03);
        check("ma_pos", 32'({sy, sx}), 32'h0);
        check("ma_no_uf", 32'(underflow), 32'h0);
        cnt = 0;
        while (!running && cnt < 50) begin @(negedge clk_pix); cnt++; end
        check("to_restart", 32'(cnt < 50), 32'h1);
        check("restart_pos", 32'({sy, sx}), 32'h0);

        // Reset mid-line clears everything in the same cycle
        cnt = 0;
        while (!(running && sy == 10'd1 && sx == 10'd3) && cnt < 200) begin
            @(negedge clk_pix); cnt++;
        end
        check("to_midline", 32'(cnt < 200), 32'h1);
        check("pre_rst_ma", 32'(misalign), 32'h1);
        rst_pix = 1'b1;
        src_q.delete();
        #1;
        check("mid_rst_level", 32'(level), 32'h0);
        check("mid_rst_pix", 32'(pix_out), 32'h03);
        check("mid_rst_flags", 32'({running, underflow, misalign}), 32'h0);
        repeat (2) @(negedge clk_pix);
        rst_pix = 1'b0;

        // clr_status held through an underflow event: the event wins, then clears
        clr_status = 1'b1;
        enq_frame(7, 13);
        cnt = 0;
        while (!underflow && cnt < 300) begin @(negedge clk_pix); cnt++; end
        check("uf_beats_clr", 32'(cnt < 300), 32'h1);
        @(negedge clk_pix);
        check("clr_after_event", 32'(underflow), 32'h0);
        clr_status = 1'b0;

        // PREFILL=DEPTH instance: release on full, wr_ready low, push+pop holds level
        for (int i = 0; i < 16; i++) begin
            f_wr_valid = 1'b1; f_wr_data = 6'(i + 1); f_wr_sof = (i == 0);
            if (i == 15) check("f_lvl15", 32'({f_running, f_wr_ready, f_level}), 32'h2F);
            @(negedge clk_pix);
        end
        f_wr_valid = 1'b0;
        check("f_full", 32'({f_running, f_wr_ready, f_level}), 32'h10);
        @(negedge clk_pix);
        check("f_run", 32'({f_running, f_level}), 32'h30);
        f_de = 1'b1; f_wr_valid = 1'b1; f_wr_data = 6'h3F; f_wr_sof = 1'b0;
        #1;
        check("f_first_pix", 32'(f_pix_out), 32'h04);
        @(negedge clk_pix);
        check("f_blocked_push", 32'(f_level), 32'd15);
        f_sx = 10'd1;
        #1;
        check("f_second_pix", 32'(f_pix_out), 32'h08);
        @(negedge clk_pix);
        check("f_push_pop", 32'(f_level), 32'd15);
        f_de = 1'b0; f_wr_valid = 1'b0;
        check("f_no_flags", 32'({f_underflow, f_misalign}), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
